// File: rtl/msi_bus_pkg.sv
// Shared snoop-bus encodings: MSI bus commands and arbiter FSM state codes.
// Imported by the bus arbiter and by the per-core L1 controllers.
package msi_bus_pkg;

    localparam logic [1:0] CMD_WB      = 2'b00;
    localparam logic [1:0] CMD_BUSRD   = 2'b01;
    localparam logic [1:0] CMD_BUSRDX  = 2'b10;
    localparam logic [1:0] CMD_BUSUPGR = 2'b11;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SNOOP  = 3'd1;
    localparam logic [2:0] ST_MEM_RD = 3'd2;
    localparam logic [2:0] ST_MEM_WR = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        SNOOP  = ST_SNOOP,
        MEM_RD = ST_MEM_RD,
        MEM_WR = ST_MEM_WR,
        DONE   = ST_DONE
    } bus_state_t;

    // Commands whose DONE cycle carries a fill-data broadcast
    function automatic logic is_fill_cmd(input logic [1:0] cmd);
        return (cmd == CMD_BUSRD) || (cmd == CMD_BUSRDX);
    endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter; the preference flips away from a core once
// its transaction completes (update pulse), not at grant time.
module rr_arbiter_2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    input  logic       owner,
    output logic       grant_valid,
    output logic       grant_idx
);

    logic pref_r;

    // Preference pointer: core 0 after reset, otherwise the core not served last
    always_ff @(posedge clk) begin
        if (rst) begin
            pref_r <= 1'b0;
        end else if (update) begin
            pref_r <= ~owner;
        end else begin
            pref_r <= pref_r;
        end
    end

    // Grant selection
    always_comb begin
        grant_valid = req[0] | req[1];
        if (req == 2'b11) begin
            grant_idx = pref_r;
        end else begin
            grant_idx = req[1];
        end
    end

endmodule

// File: rtl/msi_snoop_bus_arbiter.sv
// Snoop-bus sequencer for the dual-core MSI cache system: arbitrates the two
// L1 controllers, broadcasts each transaction, and sources data from a flush or memory.
module msi_snoop_bus_arbiter
    import msi_bus_pkg::*;
#(
    parameter int ADDR_BITS = 11,
    parameter int DATA_BITS = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_0,
    input  logic                 req_1,
    input  logic [1:0]           cmd_0,
    input  logic [1:0]           cmd_1,
    input  logic [ADDR_BITS-1:0] addr_0,
    input  logic [ADDR_BITS-1:0] addr_1,
    input  logic [DATA_BITS-1:0] wdata_0,
    input  logic [DATA_BITS-1:0] wdata_1,
    output logic                 gnt_0,
    output logic                 gnt_1,
    output logic                 done_0,
    output logic                 done_1,
    output logic [DATA_BITS-1:0] rdata,
    output logic                 bus_valid,
    output logic [1:0]           bus_cmd,
    output logic [ADDR_BITS-1:0] bus_addr,
    output logic [DATA_BITS-1:0] bus_data,
    input  logic                 snoop_flush,
    input  logic [DATA_BITS-1:0] snoop_data,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [DATA_BITS-1:0] mem_wdata,
    input  logic                 mem_ack,
    input  logic [DATA_BITS-1:0] mem_rdata
);

    localparam logic [ADDR_BITS-1:0] ADDR_ZERO = {ADDR_BITS{1'b0}};
    localparam logic [DATA_BITS-1:0] DATA_ZERO = {DATA_BITS{1'b0}};

    bus_state_t           state_r, state_s;
    logic                 owner_r, owner_s;
    logic [1:0]           cmd_r, cmd_s;
    logic [ADDR_BITS-1:0] addr_r, addr_s;
    logic [DATA_BITS-1:0] wdata_r, wdata_s;
    logic [DATA_BITS-1:0] data_r, data_s;
    logic                 update_s;
    logic                 arb_valid_s, arb_idx_s;
    logic                 fill_s;

    rr_arbiter_2 u_rr (
        .clk         (clk),
        .rst         (rst),
        .req         ({req_1, req_0}),
        .update      (update_s),
        .owner       (owner_r),
        .grant_valid (arb_valid_s),
        .grant_idx   (arb_idx_s)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state and transaction latches
    always_comb begin
        state_s  = state_r;
        owner_s  = owner_r;
        cmd_s    = cmd_r;
        addr_s   = addr_r;
        wdata_s  = wdata_r;
        data_s   = data_r;
        update_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (arb_valid_s) begin
                    owner_s = arb_idx_s;
                    cmd_s   = arb_idx_s ? cmd_1   : cmd_0;
                    addr_s  = arb_idx_s ? addr_1  : addr_0;
                    wdata_s = arb_idx_s ? wdata_1 : wdata_0;
                    data_s  = DATA_ZERO;
                    state_s = SNOOP;
                end else begin
                    state_s = IDLE;
                end
            end
            SNOOP: begin
                case (cmd_r)
                    CMD_BUSUPGR: state_s = DONE;
                    CMD_WB:      state_s = MEM_WR;
                    default: begin
                        if (snoop_flush) begin
                            data_s  = snoop_data;
                            state_s = MEM_WR;
                        end else begin
                            state_s = MEM_RD;
                        end
                    end
                endcase
            end
            MEM_RD: begin
                if (mem_ack) begin
                    data_s  = mem_rdata;
                    state_s = DONE;
                end else begin
                    state_s = MEM_RD;
                end
            end
            MEM_WR: begin
                if (mem_ack) begin
                    state_s = DONE;
                end else begin
                    state_s = MEM_WR;
                end
            end
            DONE: begin
                update_s = 1'b1;
                state_s  = IDLE;
            end
            default: state_s = IDLE;
        endcase
    end

    assign fill_s = (state_s == DONE) && is_fill_cmd(cmd_s);

    // Transaction latches and outputs, registered from the upcoming state
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_r   <= 1'b0;
            cmd_r     <= 2'b00;
            addr_r    <= ADDR_ZERO;
            wdata_r   <= DATA_ZERO;
            data_r    <= DATA_ZERO;
            gnt_0     <= 1'b0;
            gnt_1     <= 1'b0;
            done_0    <= 1'b0;
            done_1    <= 1'b0;
            rdata     <= DATA_ZERO;
            bus_valid <= 1'b0;
            bus_cmd   <= 2'b00;
            bus_addr  <= ADDR_ZERO;
            bus_data  <= DATA_ZERO;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= ADDR_ZERO;
            mem_wdata <= DATA_ZERO;
        end else begin
            owner_r   <= owner_s;
            cmd_r     <= cmd_s;
            addr_r    <= addr_s;
            wdata_r   <= wdata_s;
            data_r    <= data_s;
            gnt_0     <= (state_s != IDLE) && (owner_s == 1'b0);
            gnt_1     <= (state_s != IDLE) && (owner_s == 1'b1);
            done_0    <= (state_s == DONE) && (owner_s == 1'b0);
            done_1    <= (state_s == DONE) && (owner_s == 1'b1);
            rdata     <= (state_s == DONE) ? data_s : DATA_ZERO;
            bus_valid <= (state_s == SNOOP) || fill_s;
            bus_cmd   <= (state_s == SNOOP) ? cmd_s : (fill_s ? CMD_BUSRD : 2'b00);
            bus_addr  <= ((state_s == SNOOP) || fill_s) ? addr_s : ADDR_ZERO;
            if (state_s == SNOOP) begin
                bus_data <= (cmd_s == CMD_WB) ? wdata_s : DATA_ZERO;
            end else if (fill_s) begin
                bus_data <= data_s;
            end else begin
                bus_data <= DATA_ZERO;
            end
            mem_req   <= (state_s == MEM_RD) || (state_s == MEM_WR);
            mem_we    <= (state_s == MEM_WR);
            mem_addr  <= ((state_s == MEM_RD) || (state_s == MEM_WR)) ? addr_s : ADDR_ZERO;
            // Writeback carries the core's data; a flush writes back the snooped line
            if (state_s == MEM_WR) begin
                mem_wdata <= (cmd_s == CMD_WB) ? wdata_s : data_s;
            end else begin
                mem_wdata <= DATA_ZERO;
            end
        end
    end

endmodule

// File: tb/tb_msi_snoop_bus_arbiter.sv
// Directed bench for msi_snoop_bus_arbiter: reset, BusRd miss, flush, WB,
// round-robin contention and reset abort, with hand-computed expectations.
module tb_msi_snoop_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_0, req_1;
    logic [1:0]  cmd_0, cmd_1;
    logic [10:0] addr_0, addr_1;
    logic [15:0] wdata_0, wdata_1;
    logic        gnt_0, gnt_1, done_0, done_1;
    logic [15:0] rdata;
    logic        bus_valid;
    logic [1:0]  bus_cmd;
    logic [10:0] bus_addr;
    logic [15:0] bus_data;
    logic        snoop_flush;
    logic [15:0] snoop_data;
    logic        mem_req, mem_we;
    logic [10:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack;
    logic [15:0] mem_rdata;

    int checks = 0;
    int errors = 0;
    int waits;

    msi_snoop_bus_arbiter #(.ADDR_BITS(11), .DATA_BITS(16)) dut (
        .clk(clk), .rst(rst),
        .req_0(req_0), .req_1(req_1), .cmd_0(cmd_0), .cmd_1(cmd_1),
        .addr_0(addr_0), .addr_1(addr_1), .wdata_0(wdata_0), .wdata_1(wdata_1),
        .gnt_0(gnt_0), .gnt_1(gnt_1), .done_0(done_0), .done_1(done_1),
        .rdata(rdata), .bus_valid(bus_valid), .bus_cmd(bus_cmd),
        .bus_addr(bus_addr), .bus_data(bus_data),
        .snoop_flush(snoop_flush), .snoop_data(snoop_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        req_0 = 1'b1; cmd_0 = 2'b01; addr_0 = 11'h040; wdata_0 = 16'h0000;
        req_1 = 1'b0; cmd_1 = 2'b00; addr_1 = 11'h000; wdata_1 = 16'h0000;
        snoop_flush = 1'b0; snoop_data = 16'h0000;
        mem_ack = 1'b0; mem_rdata = 16'h0000;

        // Reset held 3 cycles with req_0 high
        repeat (3) step();
        check("rst_gnt0", gnt_0, 1'b0);
        check("rst_gnt1", gnt_1, 1'b0);
        check("rst_done", {done_1, done_0}, 2'b00);
        check("rst_bus_valid", bus_valid, 1'b0);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_rdata", rdata, 16'h0000);
        rst = 1'b0;

        // BusRd miss from core 0: SNOOP
        step();
        check("rd_gnt0", gnt_0, 1'b1);
        check("rd_snoop_valid", bus_valid, 1'b1);
        check("rd_snoop_cmd", bus_cmd, 2'b01);
        check("rd_snoop_addr", bus_addr, 11'h040);
        check("rd_snoop_data", bus_data, 16'h0000);
        step();
        check("rd_mem_req", mem_req, 1'b1);
        check("rd_mem_we", mem_we, 1'b0);
        check("rd_mem_addr", mem_addr, 11'h040);
        check("rd_memrd_bus_valid", bus_valid, 1'b0);
        waits = 0;
        repeat (2) begin
            step();
            if (mem_req) waits++;
        end
        check("rd_wait_cycles", waits, 2);
        mem_ack = 1'b1; mem_rdata = 16'h1111;
        step();
        mem_ack = 1'b0; req_0 = 1'b0;
        check("rd_done0", done_0, 1'b1);
        check("rd_done1", done_1, 1'b0);
        check("rd_rdata", rdata, 16'h1111);
        check("rd_fill_valid", bus_valid, 1'b1);
        check("rd_fill_cmd", bus_cmd, 2'b01);
        check("rd_fill_data", bus_data, 16'h1111);
        check("rd_done_mem_req", mem_req, 1'b0);
        step();
        check("rd_idle_gnt0", gnt_0, 1'b0);
        check("rd_idle_done0", done_0, 1'b0);

        // Flush: core 1 BusRd hits a modified line in core 0
        req_1 = 1'b1; cmd_1 = 2'b01; addr_1 = 11'h040;
        snoop_flush = 1'b1; snoop_data = 16'hABCD;
        step();
        check("fl_gnt1", gnt_1, 1'b1);
        check("fl_gnt0", gnt_0, 1'b0);
        check("fl_snoop_valid", bus_valid, 1'b1);
        step();
        snoop_flush = 1'b0; snoop_data = 16'h0000;
        check("fl_mem_req", mem_req, 1'b1);
        check("fl_mem_we", mem_we, 1'b1);
        check("fl_mem_addr", mem_addr, 11'h040);
        check("fl_mem_wdata", mem_wdata, 16'hABCD);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0; req_1 = 1'b0;
        check("fl_done1", done_1, 1'b1);
        check("fl_rdata", rdata, 16'hABCD);
        check("fl_fill_data", bus_data, 16'hABCD);
        step();
        check("fl_idle_gnt1", gnt_1, 1'b0);

        // Writeback from core 1; snoop_flush must be ignored
        req_1 = 1'b1; cmd_1 = 2'b00; addr_1 = 11'h0C0; wdata_1 = 16'h5678;
        snoop_flush = 1'b1; snoop_data = 16'h9999;
        step();
        check("wb_gnt1", gnt_1, 1'b1);
        check("wb_snoop_cmd", bus_cmd, 2'b00);
        check("wb_snoop_addr", bus_addr, 11'h0C0);
        check("wb_snoop_data", bus_data, 16'h5678);
        step();
        snoop_flush = 1'b0;
        check("wb_mem_we", mem_we, 1'b1);
        check("wb_mem_addr", mem_addr, 11'h0C0);
        check("wb_mem_wdata", mem_wdata, 16'h5678);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0; req_1 = 1'b0;
        check("wb_done1", done_1, 1'b1);
        check("wb_rdata", rdata, 16'h0000);
        check("wb_done_bus_valid", bus_valid, 1'b0);
        step();

        // Contention: both BusUpgr held; last owner was core 1 so core 0 leads
        req_0 = 1'b1; cmd_0 = 2'b11; addr_0 = 11'h100;
        req_1 = 1'b1; cmd_1 = 2'b11; addr_1 = 11'h200;
        for (int i = 0; i < 4; i++) begin
            step();
            check("ct_gnt", {gnt_1, gnt_0}, (i % 2 == 0) ? 2'b01 : 2'b10);
            check("ct_snoop_cmd", bus_cmd, 2'b11);
            check("ct_snoop_addr", bus_addr, (i % 2 == 0) ? 11'h100 : 11'h200);
            step();
            check("ct_done", {done_1, done_0}, (i % 2 == 0) ? 2'b01 : 2'b10);
            check("ct_done_bus_valid", bus_valid, 1'b0);
            check("ct_done_mem_req", mem_req, 1'b0);
            step();
            check("ct_idle_gnt", {gnt_1, gnt_0}, 2'b00);
        end
        req_0 = 1'b0; req_1 = 1'b0;
        step();

        // Abort: reset during MEM_RD, then a late mem_ack
        req_0 = 1'b1; cmd_0 = 2'b10; addr_0 = 11'h300;
        step();
        step();
        check("ab_mem_req", mem_req, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0; req_0 = 1'b0; mem_ack = 1'b1; mem_rdata = 16'h2222;
        check("ab_mem_req_drop", mem_req, 1'b0);
        check("ab_gnt0", gnt_0, 1'b0);
        check("ab_done0", done_0, 1'b0);
        step();
        mem_ack = 1'b0;
        check("ab_late_ack_done", {done_1, done_0}, 2'b00);
        check("ab_late_ack_mem_req", mem_req, 1'b0);
        check("ab_late_ack_gnt", {gnt_1, gnt_0}, 2'b00);

        // After reset both request: core 0 preferred
        req_0 = 1'b1; cmd_0 = 2'b11; req_1 = 1'b1; cmd_1 = 2'b11;
        step();
        check("post_rst_gnt", {gnt_1, gnt_0}, 2'b01);
        step();
        req_0 = 1'b0; req_1 = 1'b0;
        check("post_rst_done", {done_1, done_0}, 2'b01);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
